uart_rx_status: RTL and testbench



---
 rtl/uart_rx_status.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_status.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_status.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_status : 16x oversampling 8N1 UART receiver with LED status |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module uart_rx_status #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int HOLD_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic [3:0] state,
  output logic       data_ready
);

  localparam int DIV    = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_DATA  = 4'd2,
    S_STOP  = 4'd3,
    S_DONE  = 4'd4,
    S_FERR  = 4'd5
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              rx_s_q, rx_s_d;
  logic              rx_p_q, rx_p_d;
  logic [1:0]        fill_q, fill_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        samp_q, samp_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              s7_q, s7_d;
  logic              s8_q, s8_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              ferr_q, ferr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic tick;
  logic at7;
  logic at8;
  logic at9;
  logic maj;
  logic start_edge;
  logic start_ok;
  logic stop_good;
  logic stop_bad;

  assign tick = (div_q == DIV_LAST);
  assign at7  = tick && (samp_q == 4'd7);
  assign at8  = tick && (samp_q == 4'd8);
  assign at9  = tick && (samp_q == 4'd9);
  assign maj  = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

  // The synchroniser resets to 1, so a line low at reset release would look
  // like a falling edge; edges are ignored until rx_p carries real line data.
  assign start_edge = rx_p_q && !rx_s_q && (fill_q == 2'd3);
  assign start_ok   = (state_q == S_START) && at7 && !rx_s_q;
  assign stop_good  = (state_q == S_STOP) && at9 && maj;
  assign stop_bad   = (state_q == S_STOP) && at9 && !maj;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_START;
      S_START: if (at7) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (at9 && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (at9) state_d = maj ? S_DONE : S_FERR;
      S_DONE:  state_d = S_IDLE;
      S_FERR:  if (tick && rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync1_d = rx;
    rx_s_d  = sync1_q;
    rx_p_d  = rx_s_q;
    fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    div_d   = tick ? '0 : div_q + DIV_W'(1);

    samp_d = samp_q;
    if (tick) begin
      samp_d = samp_q + 4'd1;
    end
    // Loading 10 on the start-bit count-7 tick puts count 9 exactly 16 ticks on.
    if (start_ok) begin
      samp_d = 4'd10;
    end
    if ((state_q == S_IDLE) && start_edge) begin
      samp_d = 4'd0;
    end

    s7_d = at7 ? rx_s_q : s7_q;
    s8_d = at8 ? rx_s_q : s8_q;

    bit_d   = bit_q;
    shift_d = shift_q;
    if (start_ok) begin
      bit_d = 3'd0;
    end else if ((state_q == S_DATA) && at9) begin
      bit_d   = bit_q + 3'd1;
      shift_d = {maj, shift_q[7:1]};
    end

    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    ferr_d       = stop_bad;
    hold_d       = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
    // Registered on the DONE entry edge so data_out, data_valid, state=DONE and
    // the freshly loaded hold count all appear in the same clock.
    if (stop_good) begin
      data_out_d   = shift_q;
      data_valid_d = 1'b1;
      hold_d       = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_p_q       <= 1'b1;
      fill_q       <= 2'd0;
      div_q        <= '0;
      samp_q       <= 4'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      s7_q         <= 1'b0;
      s8_q         <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      rx_p_q       <= rx_p_d;
      fill_q       <= fill_d;
      div_q        <= div_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      ferr_q       <= ferr_d;
      hold_q       <= hold_d;
    end
  end

  assign state         = state_q;
  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign framing_error = ferr_q;
  assign data_ready    = (hold_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_status.sv
`default_nettype none
// tb_uart_rx_status: table-driven 8N1 frames with a data_out scoreboard and
// hand-written glitch, back-to-back, data_ready and mid-frame reset sequences.
module tb_uart_rx_status;

  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic [3:0] state;
  logic       data_ready;

  uart_rx_status #(
    .CLK_FREQ   (16_000_000),
    .BAUD       (1_000_000),
    .HOLD_CYCLES(100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .state        (state),
    .data_ready   (data_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        exp_dv;
    logic        exp_fe;
    logic [31:0] exp_seq;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         start_cyc;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         dr_cnt = 0;
  int         last_dv_cyc = 0;
  int         last_dr_cyc = 0;
  logic       dr_at_dv = 1'b0;
  logic [3:0] prev_state = 4'd0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];
  logic [3:0] state_log[$];
  vec_t       vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock: advance to the falling edge, then observe the DUT outputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (state !== prev_state) begin
      state_log.push_back(state);
      prev_state = state;
    end
    if (data_valid === 1'b1) begin
      dv_cnt++;
      last_dv_cyc = cyc;
      dr_at_dv = data_ready;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_valid: data_out=0x%02h with no byte expected", data_out);
      end else begin
        check("sb_data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
    if (framing_error === 1'b1) fe_cnt++;
    if (data_ready === 1'b1) begin
      dr_cnt++;
      last_dr_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_cyc = cyc;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CLKS);
    end
    rx = stop;
    idle(BIT_CLKS);
    rx = 1'b1;
  endtask

  function automatic logic [31:0] seq_since(input int base);
    logic [31:0] s;
    s = 32'd0;
    for (int i = base; i < state_log.size(); i++) s = {s[27:0], state_log[i]};
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_framing_error"}, 32'(framing_error), 32'd0);
    check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
  endtask

  initial begin
    int dv0;
    int fe0;
    int dr0;
    int lb;

    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_dv: 1'b1, exp_fe: 1'b0, exp_seq: 32'h0001_2340};
    vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_dv: 1'b0, exp_fe: 1'b1, exp_seq: 32'h0001_2350};
    vecs[2] = '{data: 8'hC6, stop: 1'b1, exp_dv: 1'b1, exp_fe: 1'b0, exp_seq: 32'h0001_2340};
    vecs[3] = '{data: 8'h01, stop: 1'b1, exp_dv: 1'b1, exp_fe: 1'b0, exp_seq: 32'h0001_2340};

    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(20);

    for (int i = 0; i < 4; i++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      lb  = state_log.size();
      if (vecs[i].exp_dv) begin
        exp_q.push_back(vecs[i].data);
        last_good = vecs[i].data;
      end
      send_byte(vecs[i].data, vecs[i].stop);
      idle(48);
      check("vec_dv_count", 32'(dv_cnt - dv0), 32'(vecs[i].exp_dv));
      check("vec_fe_cycles", 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      check("vec_state_seq", seq_since(lb), vecs[i].exp_seq);
      check("vec_state_len", 32'(state_log.size() - lb), 32'd5);
      check("vec_data_out", 32'(data_out), 32'(last_good));
      check("vec_sb_drained", 32'(exp_q.size()), 32'd0);
      if (vecs[i].exp_dv) check_range("vec_dv_latency", last_dv_cyc - start_cyc, 154, 156);
    end

    // 3-clock low glitch on the idle line
    dv0 = dv_cnt;
    lb  = state_log.size();
    rx  = 1'b0;
    idle(3);
    rx  = 1'b1;
    idle(40);
    check("glitch_state_seq", seq_since(lb), 32'h10);
    check("glitch_state_len", 32'(state_log.size() - lb), 32'd2);
    check("glitch_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_data_out", 32'(data_out), 32'(last_good));

    // Back-to-back frames with minimum stop bits
    dv0 = dv_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    last_good = 8'hFF;
    idle(48);
    check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
    check("b2b_sb_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_data_out", 32'(data_out), 32'hFF);

    // data_ready stretching: first byte, then a second starting 40 clocks after its strobe
    idle(120);
    check("dr_idle_low", 32'(data_ready), 32'd0);
    dr0 = dr_cnt;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    check("dr_at_first_dv", 32'(dr_at_dv), 32'd1);
    idle(40 - (cyc - last_dv_cyc));
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b1);
    last_good = 8'h96;
    idle(130);
    check("dr_total_high_cycles", 32'(dr_cnt - dr0), 32'd200);
    check("dr_last_high_after_dv", 32'(last_dr_cyc - last_dv_cyc), 32'd99);
    check("dr_at_second_dv", 32'(dr_at_dv), 32'd1);
    check("dr_final_low", 32'(data_ready), 32'd0);
    check("dr_data_out", 32'(data_out), 32'h96);

    // Reset asserted during bit 4 of a frame (0x0F: bit 4 is low)
    rx = 1'b0;
    idle(BIT_CLKS);
    rx = 1'b1;
    idle(4 * BIT_CLKS);
    rx = 1'b0;
    idle(BIT_CLKS / 2);
    check("pre_reset_state_data", 32'(state), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    idle(3);
    rst_n = 1'b1;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    lb  = state_log.size();
    idle(60);
    check("low_after_reset_no_start", 32'(state_log.size() - lb), 32'd0);
    check("low_after_reset_no_dv", 32'(dv_cnt - dv0), 32'd0);
    rx = 1'b1;
    idle(30);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    idle(48);
    check("post_reset_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("post_reset_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("post_reset_data_out", 32'(data_out), 32'h3C);
    check("post_reset_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
